// File: rtl/ppct_pkg.sv
// ppct_pkg: shared sizing constants, theta type and the row-mask helper for the PPCT multiplier
package ppct_pkg;
  localparam int PPCT_WIDTH = 8;
  localparam int PPCT_NREQ  = 4;
  localparam int PPCT_IDW   = $clog2(PPCT_NREQ);
  localparam int PPCT_THW   = $clog2(PPCT_WIDTH);

  typedef logic [PPCT_THW-1:0] theta_t;

  // Returns x with its low (theta-i) bits cleared for rows below theta, x unchanged otherwise.
  // Works on a 32-bit container so any operand width up to 32 can share it.
  function automatic logic [31:0] row_mask(input logic [31:0] x, input int theta, input int i);
    logic [31:0] m;
    m = (i < theta) ? ((32'd1 << (theta - i)) - 32'd1) : 32'd0;
    return x & ~m;
  endfunction
endpackage

// File: rtl/ppct_column_approx_dyn.sv
// ppct_column_approx_dyn: combinational column-truncated multiplier with a runtime truncation depth
module ppct_column_approx_dyn
  import ppct_pkg::*;
#(
  parameter int WIDTH = PPCT_WIDTH,
  localparam int THW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic [THW-1:0]     theta,
  output logic [2*WIDTH-1:0] z
);
  logic [THW-1:0] w_th;

  // Only a non-power-of-two width can encode theta >= WIDTH; clamp those to the deepest legal row.
  if ((1 << THW) > WIDTH) begin : g_clamp
    assign w_th = (theta > THW'(WIDTH - 1)) ? THW'(WIDTH - 1) : theta;
  end else begin : g_pass
    assign w_th = theta;
  end

  // Sum the y-gated partial-product rows, masking the low columns of the rows below theta.
  always_comb begin
    z = '0;
    for (int i = 0; i < WIDTH; i++)
      z = y[i] ? z + ((2*WIDTH)'(WIDTH'(row_mask(32'(x), int'(w_th), i))) << i) : z;
  end
endmodule

// File: rtl/ppct_mult_sched.sv
// ppct_mult_sched: round-robin scheduler sharing one two-stage approximate multiplier among NREQ lanes
module ppct_mult_sched
  import ppct_pkg::*;
#(
  parameter int WIDTH = PPCT_WIDTH,
  parameter int NREQ  = PPCT_NREQ,
  localparam int IDW  = $clog2(NREQ),
  localparam int THW  = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_x,
  input  logic [NREQ*WIDTH-1:0] req_y,
  input  logic [NREQ*THW-1:0]   req_theta,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*WIDTH-1:0]    rsp_z,
  output logic [IDW-1:0]        rsp_id
);
  logic [IDW-1:0]     r_rr_ptr;
  logic               r_run;
  logic               r_a_valid;
  logic [WIDTH-1:0]   r_a_x;
  logic [WIDTH-1:0]   r_a_y;
  logic [THW-1:0]     r_a_theta;
  logic [IDW-1:0]     r_a_id;
  logic               r_b_valid;
  logic [2*WIDTH-1:0] r_b_z;
  logic [IDW-1:0]     r_b_id;
  logic [IDW-1:0]     w_grant;
  logic               w_any;
  logic               w_b_take;
  logic               w_a_load;
  logic               w_hs;
  logic [2*WIDTH-1:0] w_z;

  assign w_b_take = !r_b_valid || rsp_ready;
  assign w_a_load = !r_a_valid || w_b_take;
  assign w_hs     = r_run && w_any && w_a_load;

  // Pick the first valid requester at or after rr_ptr; iterating downward leaves the nearest one.
  always_comb begin
    w_any   = 1'b0;
    w_grant = r_rr_ptr;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req_valid[r_rr_ptr + IDW'(k)]) begin
        w_any   = 1'b1;
        w_grant = r_rr_ptr + IDW'(k);
      end
  end

  // Only the granted lane sees ready, and only when stage A can take a new request.
  always_comb begin
    req_ready = '0;
    req_ready[w_grant] = w_hs;
  end

  ppct_column_approx_dyn #(.WIDTH(WIDTH)) u_mult (
    .x     (r_a_x),
    .y     (r_a_y),
    .theta (r_a_theta),
    .z     (w_z)
  );

  // Arbiter pointer and the run flag that keeps req_ready low until the first clock after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
      r_run    <= 1'b0;
    end else begin
      r_run    <= 1'b1;
      r_rr_ptr <= w_hs ? w_grant + IDW'(1) : r_rr_ptr;
    end
  end

  // Stage A captures operands at the handshake; it empties when B drains it with nothing new.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_valid <= 1'b0;
      r_a_x     <= '0;
      r_a_y     <= '0;
      r_a_theta <= '0;
      r_a_id    <= '0;
    end else if (w_a_load) begin
      r_a_valid <= w_hs;
      if (w_hs) begin
        r_a_x     <= req_x[w_grant*WIDTH +: WIDTH];
        r_a_y     <= req_y[w_grant*WIDTH +: WIDTH];
        r_a_theta <= req_theta[w_grant*THW +: THW];
        r_a_id    <= w_grant;
      end
    end
  end

  // Stage B takes the multiplier result whenever it is empty or the consumer is accepting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b_valid <= 1'b0;
      r_b_z     <= '0;
      r_b_id    <= '0;
    end else if (w_b_take) begin
      r_b_valid <= r_a_valid;
      r_b_z     <= w_z;
      r_b_id    <= r_a_id;
    end
  end

  assign rsp_valid = r_b_valid;
  assign rsp_z     = r_b_z;
  assign rsp_id    = r_b_id;
endmodule

// File: tb/tb_ppct_mult_sched.sv
// tb_ppct_mult_sched: directed stimulus with a per-cycle reference model and literal anchors
module tb_ppct_mult_sched;
  localparam int W = 8;
  localparam int N = 4;
  localparam int TH = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_x;
  logic [N*W-1:0]  req_y;
  logic [N*TH-1:0] req_theta;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [2*W-1:0]  rsp_z;
  logic [1:0]      rsp_id;

  int n_checks = 0;
  int n_errors = 0;

  ppct_mult_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_theta (req_theta),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_z     (rsp_z),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Product with each row's x rounded down to a multiple of 2^(theta-i) for rows below theta.
  function automatic int approx(input int x, input int y, input int th);
    int s = 0;
    for (int i = 0; i < W; i++)
      if (((y >> i) & 1) == 1) begin
        int k = (th > i) ? th - i : 0;
        s += ((x >> k) << k) << i;
      end
    return s;
  endfunction

  function automatic int grant_of(input logic [N-1:0] v, input int rr);
    int g = -1;
    for (int k = N - 1; k >= 0; k--)
      if (v[(rr + k) % N]) g = (rr + k) % N;
    return g;
  endfunction

  // Reference: one item may sit in the operand stage and one in the result stage.
  int m_rr, m_run, m_av, m_az, m_aid, m_bv, m_bz, m_bid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rr = 0; m_run = 0; m_av = 0; m_az = 0; m_aid = 0; m_bv = 0; m_bz = 0; m_bid = 0;
    end else begin
      int g, take, load;
      g = grant_of(req_valid, m_rr);
      take = (m_bv == 0 || rsp_ready) ? 1 : 0;
      load = (m_av == 0 || take == 1) ? 1 : 0;
      if (take == 1) begin
        m_bv = m_av; m_bz = m_az; m_bid = m_aid;
      end
      if (load == 1) begin
        m_av = (m_run == 1 && g >= 0) ? 1 : 0;
        if (m_av == 1) begin
          m_az  = approx(int'(req_x[g*W +: W]), int'(req_y[g*W +: W]), int'(req_theta[g*TH +: TH]));
          m_aid = g;
          m_rr  = (g + 1) % N;
        end
      end
      m_run = 1;
    end
  end

  // Compare the DUT against the reference on every cycle outside reset.
  always @(negedge clk) begin
    if (rst_n) begin
      int g;
      logic [N-1:0] er;
      g = grant_of(req_valid, m_rr);
      er = (m_run == 1 && g >= 0 && (m_av == 0 || m_bv == 0 || rsp_ready)) ? N'(1 << g) : '0;
      check("model_req_ready", 32'(req_ready), 32'(er));
      check("model_rsp_valid", 32'(rsp_valid), 32'(m_bv));
      if (m_bv == 1) begin
        check("model_rsp_z", 32'(rsp_z), 32'(m_bz));
        check("model_rsp_id", 32'(rsp_id), 32'(m_bid));
      end
    end
  end

  task automatic set_req(input int id, input int x, input int y, input int th);
    req_x[id*W +: W]      = W'(x);
    req_y[id*W +: W]      = W'(y);
    req_theta[id*TH +: TH] = TH'(th);
  endtask

  task automatic do_req(input string name, input int id, input int x, input int y, input int th,
                        input int exp, input int newx);
    int ok = 0;
    @(posedge clk); #1;
    set_req(id, x, y, th);
    req_valid[id] = 1'b1;
    for (int c = 0; c < 20 && ok == 0; c++) begin
      @(negedge clk);
      if (req_ready[id]) ok = 1;
    end
    check({name, "_handshake"}, 32'(ok), 32'd1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    if (newx >= 0) req_x[id*W +: W] = W'(newx);
    @(posedge clk);
    @(negedge clk);
    check({name, "_valid"}, 32'(rsp_valid), 32'd1);
    check({name, "_z"}, 32'(rsp_z), 32'(exp));
    check({name, "_id"}, 32'(rsp_id), 32'(id));
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_x = '0;
    req_y = '0;
    req_theta = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_z", 32'(rsp_z), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_req("exact", 0, 255, 255, 0, 65025, -1);
    do_req("th2", 2, 255, 255, 2, 65020, -1);
    do_req("th1", 1, 3, 3, 1, 8, -1);
    do_req("th2_zero", 3, 3, 1, 2, 0, -1);
    do_req("sampled", 1, 10, 10, 0, 100, 99);

    // Backpressure with all lanes requesting.
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) set_req(i, 17 + 40 * i, 200 - 30 * i, i);
    req_valid = '1;
    rsp_ready = 1'b0;
    repeat (5) @(negedge clk);
    check("stall_req_ready", 32'(req_ready), 32'd0);
    check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 req_valid = '0;
    repeat (4) @(posedge clk);

    // Reset with both stages full, then verify round-robin order from a fresh pointer.
    #1 req_valid = '1;
    rsp_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midreset_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("post_reset_first_cycle_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("post_reset_grant0", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rr_valid", 32'(rsp_valid), 32'd1);
      check("rr_id", 32'(rsp_id), 32'(k % N));
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
